// File: rtl/audio_pkg.sv
// Shared types and constants for the audio prescale path.
//   tone_state_t : note sequencer states (IDLE, PLAY, GAP)
//   PS_W         : width of the tone prescale value
//   HALF_SHIFT   : half-period = prescale << HALF_SHIFT clocks
//   SAMPLE_W     : width of the signed codec sample
//   PS_ZERO      : prescale value that means "no tone"
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

  localparam int unsigned PS_W       = 10;
  localparam int unsigned HALF_SHIFT = 7;
  localparam int unsigned SAMPLE_W   = 16;

  localparam logic [PS_W-1:0] PS_ZERO = 10'h000;

endpackage

// File: rtl/tone_divider.sv
// Half-period divider producing the square-wave phase of a tone.
//   clk, resetN : system clock, asynchronous active-low reset
//   enable      : advance the half-period counter this cycle (in PLAY)
//   restart     : PLAY entry or retrigger; counter to 0, phase to 1
//   curPs       : current prescale; half-period = curPs * 128 clocks
//   phase       : square-wave phase, forced to 0 when neither enabled nor restarting
module tone_divider
  import audio_pkg::*;
(
  input  logic            clk,
  input  logic            resetN,
  input  logic            enable,
  input  logic            restart,
  input  logic [PS_W-1:0] curPs,
  output logic            phase
);

  localparam int unsigned CNT_W = PS_W + HALF_SHIFT;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] terminal;

  assign terminal = {curPs, {HALF_SHIFT{1'b0}}} - CNT_W'(1);

  // curPs is updated on the same edge as restart, so the first half-period
  // after a restart already compares against the new terminal.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (enable) begin
      if (cnt == terminal) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt   <= '0;
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/tone_player.sv
// Timed square-wave tone player: PLAY for DUR_CYCLES, then a GAP_CYCLES gap.
//   clk, resetN   : 25 MHz system clock, asynchronous active-low reset
//   preScaleValue : tone prescale, sampled only when playReq=1 (0 = ignored)
//   playReq       : one-cycle play strobe
//   busy          : high in PLAY or GAP
//   toneActive    : high in PLAY
//   done          : one-cycle pulse, first cycle after a note expires
//   squareOut     : buzzer square wave, 0 outside PLAY
//   sampleOut     : signed codec sample, +/-amplitude in PLAY, 0 otherwise
// Optional build macro TONE_DECAY_EN: amplitude halves at each quarter of the note.
module tone_player
  import audio_pkg::*;
#(
  parameter int unsigned         DUR_CYCLES = 2_500_000,
  parameter int unsigned         GAP_CYCLES = 250_000,
  parameter logic [SAMPLE_W-1:0] AMPLITUDE  = 16'h2000
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [PS_W-1:0]     preScaleValue,
  input  logic                playReq,
  output logic                busy,
  output logic                toneActive,
  output logic                done,
  output logic                squareOut,
  output logic [SAMPLE_W-1:0] sampleOut
);

  localparam int unsigned DUR_W = $clog2(DUR_CYCLES);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  tone_state_t     state, state_nxt;
  logic [PS_W-1:0] cur_ps, cur_ps_nxt;
  logic [PS_W-1:0] pend_ps, pend_ps_nxt;
  logic            pend, pend_nxt;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic            done_nxt;
  logic            restart;
  logic            enable;
  logic            req;
  logic            dur_last;
  logic            gap_last;

  assign req      = playReq && (preScaleValue != PS_ZERO);
  assign dur_last = (dur_cnt == DUR_W'(DUR_CYCLES - 1));
  assign gap_last = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    state_nxt   = state;
    cur_ps_nxt  = cur_ps;
    pend_ps_nxt = pend_ps;
    pend_nxt    = pend;
    dur_cnt_nxt = dur_cnt;
    gap_cnt_nxt = gap_cnt;
    done_nxt    = 1'b0;
    restart     = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nxt   = PLAY;
          cur_ps_nxt  = preScaleValue;
          dur_cnt_nxt = '0;
          restart     = 1'b1;
        end
      end
      PLAY: begin
        // A retrigger takes priority over expiry and suppresses done.
        if (req) begin
          cur_ps_nxt  = preScaleValue;
          dur_cnt_nxt = '0;
          restart     = 1'b1;
        end else if (dur_last) begin
          state_nxt   = GAP;
          dur_cnt_nxt = '0;
          gap_cnt_nxt = '0;
          done_nxt    = 1'b1;
        end else begin
          dur_cnt_nxt = dur_cnt + DUR_W'(1);
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_nxt = '0;
          pend_nxt    = 1'b0;
          if (req || pend) begin
            state_nxt   = PLAY;
            cur_ps_nxt  = req ? preScaleValue : pend_ps;
            dur_cnt_nxt = '0;
            restart     = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
          if (req) begin
            pend_nxt    = 1'b1;
            pend_ps_nxt = preScaleValue;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enable = (state == PLAY) && (state_nxt == PLAY) && !restart;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cur_ps     <= '0;
      pend_ps    <= '0;
      pend       <= 1'b0;
      dur_cnt    <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      toneActive <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_ps     <= cur_ps_nxt;
      pend_ps    <= pend_ps_nxt;
      pend       <= pend_nxt;
      dur_cnt    <= dur_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      busy       <= (state_nxt != IDLE);
      toneActive <= (state_nxt == PLAY);
      done       <= done_nxt;
    end
  end

  tone_divider u_divider (
    .clk     (clk),
    .resetN  (resetN),
    .enable  (enable),
    .restart (restart),
    .curPs   (cur_ps_nxt),
    .phase   (squareOut)
  );

  logic [SAMPLE_W-1:0] mag;

`ifdef TONE_DECAY_EN
  localparam int unsigned QUARTER = DUR_CYCLES / 4;
  logic [1:0] q;

  always_comb begin
    q = 2'd0;
    if (32'(dur_cnt) >= 3 * QUARTER)      q = 2'd3;
    else if (32'(dur_cnt) >= 2 * QUARTER) q = 2'd2;
    else if (32'(dur_cnt) >= QUARTER)     q = 2'd1;
  end

  assign mag = SAMPLE_W'($signed(AMPLITUDE) >>> q);
`else
  assign mag = AMPLITUDE;
`endif

  // Decoded only from flops (toneActive, phase, duration counter), so the
  // sample carries no combinational path from the inputs.
  always_comb begin
    sampleOut = '0;
    if (toneActive) sampleOut = squareOut ? mag : (~mag + SAMPLE_W'(1));
  end

endmodule
